// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings and writeback FSM states.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_t;

  localparam int XLEN = 16;
  localparam int RIDX = 3;

endpackage

// File: rtl/writeback_regfile.sv
// Register file: one write port, two asynchronous read ports, r0 reads zero.
module regfile
  import cpu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RIDX-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RIDX-1:0] ra_addr,
  input  logic [RIDX-1:0] rb_addr,
  output logic [XLEN-1:0] ra_data,
  output logic [XLEN-1:0] rb_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/writeback.sv
// Writeback stage: regfile write, halt FSM, retire counter.
// Optional write-through read bypass enabled by WB_BYPASS_EN.
module writeback
  import cpu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble_in,
  input  logic [2:0]  opcode_in,
  input  logic [2:0]  tgt_in,
  input  logic [15:0] result_in,
  input  logic [15:0] mem_data_in,
  input  logic        halt_in,
  input  logic [2:0]  ra_addr,
  input  logic [2:0]  rb_addr,
  output logic [15:0] ra_data,
  output logic [15:0] rb_data,
  output logic        fwd_valid,
  output logic [2:0]  fwd_tgt,
  output logic [15:0] fwd_data,
  output logic        halted,
  output logic [15:0] retired
);

  wb_state_t       state;
  opcode_t         op;
  logic            we;
  logic [15:0]     wdata;
  logic [15:0]     rf_ra;
  logic [15:0]     rf_rb;

  assign op    = opcode_t'(opcode_in);
  assign wdata = (op == OP_LW) ? mem_data_in : result_in;
  assign we    = !bubble_in && state == ST_RUN &&
                 tgt_in != '0 &&
                 op != OP_SW && op != OP_BEQ;

  assign fwd_valid = we;
  assign fwd_tgt   = tgt_in;
  assign fwd_data  = wdata;

  regfile #(.NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (tgt_in),
    .wdata   (wdata),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (rf_ra),
    .rb_data (rf_rb)
  );

`ifdef WB_BYPASS_EN
  assign ra_data = (we && ra_addr == tgt_in) ? wdata : rf_ra;
  assign rb_data = (we && rb_addr == tgt_in) ? wdata : rf_rb;
`else
  assign ra_data = rf_ra;
  assign rb_data = rf_rb;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!bubble_in) begin
            if (retired != 16'hFFFF)
              retired <= retired + 16'd1;
            if (halt_in) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: reference model plus scoreboard queue.
module tb_writeback;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bubble_in;
  logic [2:0]  opcode_in;
  logic [2:0]  tgt_in;
  logic [15:0] result_in;
  logic [15:0] mem_data_in;
  logic        halt_in;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic        fwd_valid;
  logic [2:0]  fwd_tgt;
  logic [15:0] fwd_data;
  logic        halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  writeback #(.NREGS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bubble_in   (bubble_in),
    .opcode_in   (opcode_in),
    .tgt_in      (tgt_in),
    .result_in   (result_in),
    .mem_data_in (mem_data_in),
    .halt_in     (halt_in),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .ra_data     (ra_data),
    .rb_data     (rb_data),
    .fwd_valid   (fwd_valid),
    .fwd_tgt     (fwd_tgt),
    .fwd_data    (fwd_data),
    .halted      (halted),
    .retired     (retired)
  );

  typedef struct {
    logic        fv;
    logic [2:0]  ft;
    logic [15:0] fd;
    logic [15:0] ra;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mregs [8];
  logic [15:0] mret;
  logic        mhalt;
  int          passes = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mret  = '0;
    mhalt = 1'b0;
  endtask

  task automatic idle();
    bubble_in   = 1'b1;
    halt_in     = 1'b0;
    opcode_in   = 3'b000;
    tgt_in      = 3'd0;
    result_in   = '0;
    mem_data_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bubble_in   = 1'b0;
    halt_in     = 1'b1;
    opcode_in   = 3'b000;
    tgt_in      = 3'd1;
    result_in   = 16'hDEAD;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    model_clear();
    chk("rst_retired", retired, 16'h0);
    chk("rst_halted", halted, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp);
    @(negedge clk);
    idle();
    ra_addr = a;
    rb_addr = a;
    #1;
    chk("rd_ra", ra_data, exp);
    chk("rd_rb", rb_data, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] tgt,
                       input logic [15:0] res, input logic [15:0] mem,
                       input logic hlt, input logic bub);
    exp_t e;
    logic we_m;
    logic [15:0] wd;
    @(negedge clk);
    opcode_in   = op;
    tgt_in      = tgt;
    result_in   = res;
    mem_data_in = mem;
    halt_in     = hlt;
    bubble_in   = bub;
    we_m = !bub && !mhalt && tgt != 3'd0 &&
           op != 3'b100 && op != 3'b110;
    wd = (op == 3'b101) ? mem : res;
    e.fv = we_m;
    e.ft = tgt;
    e.fd = wd;
    if (BYP && we_m && ra_addr == tgt) e.ra = wd;
    else e.ra = (ra_addr == 3'd0) ? 16'h0 : mregs[ra_addr];
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("fwd_valid", fwd_valid, e.fv);
    if (e.fv) begin
      chk("fwd_tgt", fwd_tgt, e.ft);
      chk("fwd_data", fwd_data, e.fd);
    end
    chk("ra_same_cycle", ra_data, e.ra);
    @(posedge clk);
    if (we_m) mregs[tgt] = wd;
    if (!bub && !mhalt) begin
      if (mret != 16'hFFFF) mret = mret + 16'd1;
      if (hlt) mhalt = 1'b1;
    end
    #1;
    chk("retired", retired, mret);
    chk("halted", halted, mhalt);
  endtask

  initial begin
    rst_n   = 1'b0;
    ra_addr = 3'd0;
    rb_addr = 3'd0;
    idle();
    model_clear();
    do_reset();
    rd(3'd3, 16'h0);

    issue(3'b000, 3'd3, 16'h1234, 16'h0, 1'b0, 1'b0);
    rd(3'd3, 16'h1234);
    chk("add_retired", retired, 16'd1);

    issue(3'b101, 3'd5, 16'h00AA, 16'hBEEF, 1'b0, 1'b0);
    rd(3'd5, 16'hBEEF);

    issue(3'b100, 3'd2, 16'h7777, 16'h0, 1'b0, 1'b0);
    issue(3'b000, 3'd2, 16'h8888, 16'h0, 1'b0, 1'b1);
    rd(3'd2, 16'h0);
    chk("sw_bub_retired", retired, 16'd3);

    issue(3'b110, 3'd7, 16'h4321, 16'h0, 1'b0, 1'b0);
    rd(3'd7, 16'h0);

    rd(3'd0, 16'h0);
    issue(3'b001, 3'd0, 16'hFFFF, 16'h0, 1'b0, 1'b0);
    chk("r0_fwd_valid", fwd_valid, 1'b0);
    rd(3'd0, 16'h0);

    issue(3'b000, 3'd6, 16'h1111, 16'h0, 1'b0, 1'b0);
    rd(3'd6, 16'h1111);
    issue(3'b000, 3'd6, 16'h5555, 16'h0, 1'b0, 1'b0);
    rd(3'd6, 16'h5555);

    issue(3'b000, 3'd1, 16'h0101, 16'h0, 1'b1, 1'b1);
    chk("bubble_halt_ignored", halted, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra_addr = 3'($urandom_range(0, 7));
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom), 1'b0,
            ($urandom_range(0, 3) == 0));
    end

    ra_addr = 3'd4;
    issue(3'b000, 3'd4, 16'h0042, 16'h0, 1'b1, 1'b0);
    chk("halt_set", halted, 1'b1);
    rd(3'd4, 16'h0042);
    issue(3'b000, 3'd4, 16'h0099, 16'h0, 1'b0, 1'b0);
    rd(3'd4, 16'h0042);

    do_reset();
    rd(3'd4, 16'h0);
    rd(3'd1, 16'h0);

    @(negedge clk);
    opcode_in = 3'b100;
    tgt_in    = 3'd1;
    halt_in   = 1'b0;
    bubble_in = 1'b0;
    repeat (65540) @(posedge clk);
    mret = 16'hFFFF;
    #1;
    chk("sat_retired", retired, 16'hFFFF);
    issue(3'b100, 3'd1, 16'h0, 16'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
